// File: rtl/ooo_pkg.sv
// Shared definitions for the issue stage: queue entry layout, slot payload
// format and small helpers for decoding an entry.
package ooo_pkg;

  localparam int ENTRY_W     = 57;

  localparam int ENT_VALID   = 56;
  localparam int ENT_OP_HI   = 55;
  localparam int ENT_OP_LO   = 52;
  localparam int ENT_ROB_HI  = 51;
  localparam int ENT_ROB_LO  = 46;
  localparam int ENT_LA_HI   = 45;
  localparam int ENT_LA_LO   = 40;
  localparam int ENT_LB_HI   = 39;
  localparam int ENT_LB_LO   = 34;
  localparam int ENT_VA_HI   = 33;
  localparam int ENT_VA_LO   = 18;
  localparam int ENT_VB_HI   = 17;
  localparam int ENT_VB_LO   = 2;
  localparam int ENT_USER_HI = 1;
  localparam int ENT_USER_LO = 0;

  localparam int OP_W  = ENT_OP_HI - ENT_OP_LO + 1;
  localparam int ROB_W = ENT_ROB_HI - ENT_ROB_LO + 1;
  localparam int VAL_W = ENT_VA_HI - ENT_VA_LO + 1;

  // What a functional-unit slot carries for one issued operation.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [VAL_W-1:0] a;
    logic [VAL_W-1:0] b;
  } slot_payload_t;

  localparam int SLOT_W = $bits(slot_payload_t);

  // An entry may issue once it is valid and its user field reports both
  // operands resolved (user == 0).
  function automatic logic entry_ready(input logic [ENTRY_W-1:0] entry);
    return entry[ENT_VALID] && (entry[ENT_USER_HI:ENT_USER_LO] == 2'b00);
  endfunction

  // Extract the fields a functional unit needs from a queue entry.
  function automatic slot_payload_t entry_payload(input logic [ENTRY_W-1:0] entry);
    slot_payload_t p;
    p.op  = entry[ENT_OP_HI:ENT_OP_LO];
    p.rob = entry[ENT_ROB_HI:ENT_ROB_LO];
    p.a   = entry[ENT_VA_HI:ENT_VA_LO];
    p.b   = entry[ENT_VB_HI:ENT_VB_LO];
    return p;
  endfunction

endpackage

// File: rtl/issue_slot.sv
// One functional-unit slot: a payload register plus a valid bit that follows
// a valid/ready handshake. Flush wins over load and ready.
module issue_slot
  import ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [SLOT_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [SLOT_W-1:0] payload
);

  // Valid bit: set on load, cleared on accept or flush, otherwise held.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Payload register: only written on a load so it stays stable while the
  // slot waits for its functional unit.
  // NOTE: the payload is reset because the slot fields are visible outputs
  // that must read zero out of reset; a pure data store would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload <= '0;
    end else if (load && !flush) begin
      payload <= load_data;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler. Looks at the two queue head entries, issues
// up to two ready ones into free functional-unit slots, reports the consume
// count as taken, and keeps a saturating count of stalled head cycles.
module issue_scheduler
  import ooo_pkg::*;
#(
  parameter int ENTRY_W = ooo_pkg::ENTRY_W,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] head0,
  input  logic [ENTRY_W-1:0] head1,
  output logic [1:0]         taken,

  output logic               fu0_valid,
  output logic [3:0]         fu0_op,
  output logic [5:0]         fu0_rob,
  output logic [15:0]        fu0_a,
  output logic [15:0]        fu0_b,
  input  logic               fu0_ready,

  output logic               fu1_valid,
  output logic [3:0]         fu1_op,
  output logic [5:0]         fu1_rob,
  output logic [15:0]        fu1_a,
  output logic [15:0]        fu1_b,
  input  logic               fu1_ready,

  output logic [STALL_W-1:0] stall_cnt
);

  logic          ready0, ready1;
  logic          free0, free1;
  logic          issue0, issue1;
  logic          load0, load1;
  slot_payload_t data0, data1;
  slot_payload_t pay0, pay1;
  logic          rr;
  logic          rr_toggle;

  // Operand lookup tags are already resolved upstream once user == 0, so the
  // scheduler never needs them.
  logic unused_lookups;
  assign unused_lookups = ^{head0[ENT_LA_HI:ENT_LB_LO], head1[ENT_LA_HI:ENT_LB_LO]};

  assign ready0 = entry_ready(head0);
  assign ready1 = entry_ready(head1);

  // A draining slot counts as free so it can be refilled without a bubble.
  assign free0 = !fu0_valid || fu0_ready;
  assign free1 = !fu1_valid || fu1_ready;

  // Strictly in-order issue: head1 only goes along with head0, and only when
  // both slots can take an op.
  assign issue0 = ready0 && (free0 || free1) && !flush;
  assign issue1 = issue0 && ready1 && free0 && free1;
  assign taken  = {1'b0, issue0} + {1'b0, issue1};

  // Slot steering for the ops issued this cycle.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    load0     = 1'b0;
    load1     = 1'b0;
    data0     = entry_payload(head0);
    data1     = entry_payload(head0);
    rr_toggle = 1'b0;
    if (issue1) begin
      load0 = 1'b1;
      load1 = 1'b1;
      data1 = entry_payload(head1);
    end else if (issue0) begin
      if (free0 && free1) begin
        load0     = !rr;
        load1     = rr;
        rr_toggle = 1'b1;
      end else if (free0) begin
        load0 = 1'b1;
      end else begin
        load1 = 1'b1;
      end
    end
  end

  // Round-robin pointer: advances only on a single issue with both slots free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (rr_toggle) begin
      rr <= !rr;
    end
  end

  // Stall counter: head0 present but held back, excluding flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (head0[ENT_VALID] && !issue0 && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  issue_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load0),
    .load_data (data0),
    .ready     (fu0_ready),
    .valid     (fu0_valid),
    .payload   (pay0)
  );

  issue_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load1),
    .load_data (data1),
    .ready     (fu1_ready),
    .valid     (fu1_valid),
    .payload   (pay1)
  );

  assign fu0_op  = pay0.op;
  assign fu0_rob = pay0.rob;
  assign fu0_a   = pay0.a;
  assign fu0_b   = pay0.b;
  assign fu1_op  = pay1.op;
  assign fu1_rob = pay1.rob;
  assign fu1_a   = pay1.a;
  assign fu1_b   = pay1.b;

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

In-order dual-issue scheduler between the instruction queue and the two functional units. Each cycle it inspects the two head entries, decides how many are ready and have a free execution slot, and returns the consume count to the queue as `taken`. Issued operations are registered into one of two functional-unit slots with a valid/ready handshake. Flush empties both slots and suppresses issue.

## Interface
- `ENTRY_W`, 57: width of a queue entry.
- `STALL_W`, 16: width of the stall statistics counter.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: pipeline flush, same cycle as the queue's flush.
- `head0` in ENTRY_W: entry at queue head. Fields are [56] valid, [55:52] op, [51:46] ROB, [45:40] lookA, [39:34] lookB, [33:18] valueA, [17:2] valueB, [1:0] user.
- `head1` in ENTRY_W: entry at head+1, same format.
- `taken` out 2: entries consumed this cycle (0, 1 or 2). Combinational.
- `fu0_valid` out 1: slot 0 holds an issued op.
- `fu0_op` out 4: opcode in slot 0.
- `fu0_rob` out 6: ROB tag in slot 0.
- `fu0_a` out 16: operand A in slot 0.
- `fu0_b` out 16: operand B in slot 0.
- `fu0_ready` in 1: FU0 accepts slot 0 this cycle.
- `fu1_valid`, `fu1_op`, `fu1_rob`, `fu1_a`, `fu1_b` out: same as slot 0, for slot 1.
- `fu1_ready` in 1: FU1 accepts slot 1 this cycle.
- `stall_cnt` out STALL_W: saturating count of cycles where head0 was valid but not issued.

## Operation
- **Entry ready:** valid bit = 1 and user = 2'b00, meaning both operands are resolved. An entry with valid = 1 but nonzero user is pending.
- **Slot free:** `free_k = !fuk_valid || fuk_ready`. A draining slot may be refilled in the same cycle.
- **Issue is strictly in order:**
  - head0 issues iff it is ready, at least one slot is free, and `flush` = 0.
  - head1 issues iff head0 issues, head1 is ready, and both slots are free.
  - `taken` = number of entries issued.
- **Slot assignment:**
  - Two issue: head0 goes to slot 0, head1 to slot 1.
  - One issues, one slot free: it goes to the free slot.
  - One issues, both slots free: it goes to the slot named by the 1-bit round-robin pointer `rr`, and `rr` toggles. `rr` changes in no other case.
- **Slot register update:**
  - Loaded with {op, ROB, valueA, valueB} and `valid` = 1 when assigned.
  - Otherwise, when `fuk_ready` = 1, `valid` clears; payload is don't-care.
  - Otherwise the slot holds. Payload must stay stable while `valid` = 1 and `ready` = 0.
- **`flush`:**
  - Both slot valids clear at the next edge, regardless of `ready`.
  - `taken` = 0 in the flush cycle.
  - `rr` is unchanged.
- **`stall_cnt`:** increments when head0 valid = 1, head0 is not issued, and `flush` = 0. It saturates at all-ones and never wraps.
- **Reset** (async assert, sync deassert from upstream): all outputs 0, `rr` = 0, `stall_cnt` = 0. Asserting reset mid-handshake drops pending ops.

## Timing
- `taken` is combinational from `head0`, `head1`, slot state, `fu*_ready` and `flush`. The queue registers it.
- Latency: an op issued in cycle N has `fuk_valid` = 1 in cycle N+1.
- Throughput: 2 ops/cycle when both FUs are ready every cycle.
- Back-to-back issue to the same slot works when `ready` = 1 every cycle.
- Slot ready and refill in the same cycle means the old op transfers and the new op is visible at N+1, with no bubble.
- Both heads ready with one slot free gives `taken` = 1; head1 waits.
- head0 pending with head1 ready gives `taken` = 0 (no out-of-order issue).

## Structure
- Shared package `ooo_pkg` holds:
  - entry field offsets and widths as localparams (`ENT_VALID`, `ENT_OP_HI/LO`, `ENT_ROB_HI/LO`, `ENT_VA_HI/LO`, `ENT_VB_HI/LO`, `ENT_USER_HI/LO`);
  - `ENTRY_W`.
- One sub-module, `issue_slot`, instantiated twice: a payload register plus a valid bit with load, ready and flush inputs.
- Top level holds the issue decision, the `rr` pointer and `stall_cnt`.

## Test plan
- **Dual issue:** both heads ready (op 4'h3, ROB 5; op 4'h7, ROB 6), both slots empty → `taken` = 2; next cycle `fu0_rob` = 5 and `fu1_rob` = 6, both valid.
- **In-order block and stall count:** head0 user = 2'b10, head1 ready → `taken` = 0 and `fu*_valid` stay 0. After 3 such cycles `stall_cnt` = 3.
- **Backpressure and round-robin:** slot 0 valid with `fu0_ready` = 0, two ready heads → `taken` = 1, head0 goes to slot 1, slot 0 payload unchanged. Then release both slots, single ready head on two consecutive cycles → lands in slot 0, then slot 1 (`rr` alternates from 0).
- **Flush:** both slots valid with ready = 0, heads ready, `flush` = 1 → `taken` = 0, both valids 0 next cycle.
- **Reset mid-operation:** assert `rst_n` = 0 while slots are valid → outputs 0 immediately without a clock edge. After release with ready heads, issue resumes at slot 0.
- **Saturation:** preload `stall_cnt` near the limit by 65540 stalled cycles → it holds at 16'hFFFF.
